data_integrity_checker: RTL and testbench

Parametrised successor to the single-width data-integrity scoreboard. It has three parts:
- a DEPTH x WIDTH FIFO with real full/empty flags and overflow/underflow guarding;
- a magic-packet tracker that captures one tagged word and counts it down to the FIFO head;
- a comparator that checks the popped word against the captured copy and reports pass or fail.

It is the formal/sim checking harness around the FIFO under test. It supports re-arming for repeated checks without reset.

---
 rtl/data_integrity_checker.sv | 117 +++++++++++
 tb/tb_data_integrity_checker.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/data_integrity_checker.sv
// FIFO scoreboard: tags one pushed word, follows it to the head, and checks it on pop.
// Optional DATA_INTEGRITY_PROTO_CHK_EN adds sticky proto_err for push-on-full / pop-on-empty.
// state    | meaning
// IDLE     | no tag requested since reset
// ARMED    | waiting for the next accepted push to capture
// TRACKING | tagged word in FIFO, pos words ahead of it
// DONE     | check reported, waiting for start to re-arm
module data_integrity_checker #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full,
  output logic             armed,
  output logic             tracking,
  output logic [WIDTH-1:0] magic_data,
  output logic             check_vld,
  output logic             check_pass,
  output logic             err,
  output logic             proto_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ARMED, TRACKING, DONE} state_t;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] head;
  logic [AW:0]      wr_ptr, rd_ptr, occ, pos;
  logic             push_acc, pop_acc, capture, hit;
  state_t           state, state_nxt;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_acc = push & ~full;
  assign pop_acc  = pop & ~empty;
  assign occ      = wr_ptr - rd_ptr;
  assign head     = mem[rd_ptr[AW-1:0]];
  assign data_out = head;

  always_ff @(posedge CLK) begin
    if (push_acc) mem[wr_ptr[AW-1:0]] <= data_in;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_acc)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Capture happens in ARMED, or directly from IDLE/DONE when start meets an accepted push.
  assign capture = push_acc && ((state == ARMED) ||
                                (start && (state == IDLE || state == DONE)));
  assign hit     = (state == TRACKING) && pop_acc && (pos == '0);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (start) state_nxt = capture ? TRACKING : ARMED;
      ARMED:      if (capture) state_nxt = TRACKING;
      TRACKING:   if (hit) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    armed    = (state == ARMED);
    tracking = (state == TRACKING);
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      magic_data <= '0;
      pos        <= '0;
      check_vld  <= 1'b0;
      check_pass <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (capture) begin
        magic_data <= data_in;
        pos        <= occ - {{AW{1'b0}}, pop_acc};
      end else if (state == TRACKING && pop_acc && pos != '0) begin
        pos <= pos - PTR_ONE;
      end
      check_vld  <= hit;
      check_pass <= hit && (head == magic_data);
      if (hit && head != magic_data) err <= 1'b1;
    end
  end

`ifdef DATA_INTEGRITY_PROTO_CHK_EN
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n)                                  proto_err <= 1'b0;
    else if ((push && full) || (pop && empty))   proto_err <= 1'b1;
  end
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_integrity_checker.sv
// Directed + random bench for data_integrity_checker against a queue-based reference model.
// The model tracks the tagged word as a flag on its queue entry rather than by position.
module tb_data_integrity_checker;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic CLK = 1'b0;
  logic rst_n, push, pop, start;
  logic [WIDTH-1:0] data_in, data_out, magic_data;
  logic empty, full, armed, tracking, check_vld, check_pass, err, proto_err;

  data_integrity_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .rst_n(rst_n), .push(push), .pop(pop), .start(start),
    .data_in(data_in), .data_out(data_out), .empty(empty), .full(full),
    .armed(armed), .tracking(tracking), .magic_data(magic_data),
    .check_vld(check_vld), .check_pass(check_pass), .err(err), .proto_err(proto_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {logic [WIDTH-1:0] d; bit tag;} ent_t;
  ent_t q[$];
  bit m_armed, m_vld, m_pass, m_err, m_proto, corrupt;
  logic [WIDTH-1:0] m_magic;
  int n_assert = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_tracking();
    foreach (q[i]) if (q[i].tag) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_all();
    chk("empty", empty, q.size() == 0);
    chk("full", full, q.size() == DEPTH);
    chk("armed", armed, m_armed);
    chk("tracking", tracking, m_tracking());
    chk("magic_data", magic_data, m_magic);
    chk("check_vld", check_vld, m_vld);
    chk("check_pass", check_pass, m_pass);
    chk("err", err, m_err);
    chk("proto_err", proto_err, m_proto);
    if (q.size() != 0 && !corrupt) chk("data_out", data_out, q[0].d);
  endtask

  task automatic model_reset();
    q.delete();
    m_armed = 0; m_vld = 0; m_pass = 0; m_err = 0; m_proto = 0;
    m_magic = '0;
  endtask

  // One clock: drive, predict from pre-edge model state, clock, compare.
  task automatic step(input bit p, input bit r, input bit s, input logic [WIDTH-1:0] d);
    bit pa, ra, fm, em, cap, idle_m, vld_n, pass_n;
    push = p; pop = r; start = s; data_in = d;
    fm = (q.size() == DEPTH);
    em = (q.size() == 0);
    pa = p && !fm;
    ra = r && !em;
    idle_m = !m_armed && !m_tracking();
    vld_n = 0; pass_n = 0;
    if (ra && q[0].tag) begin
      vld_n  = 1;
      pass_n = !corrupt && (q[0].d == m_magic);
    end
    cap = pa && (m_armed || (s && idle_m));
`ifdef DATA_INTEGRITY_PROTO_CHK_EN
    if ((p && fm) || (r && em)) m_proto = 1;
`endif
    if (ra) void'(q.pop_front());
    if (pa) q.push_back('{d: d, tag: cap});
    if (cap) begin
      m_magic = d;
      m_armed = 0;
    end else if (s && idle_m) begin
      m_armed = 1;
    end
    if (vld_n && !pass_n) m_err = 1;
    m_vld = vld_n; m_pass = pass_n;
    @(posedge CLK); #1;
    check_all();
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all();
    chk("rst_vld", check_vld, 1'b0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; push = 0; pop = 0; start = 0; data_in = '0; corrupt = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_all();
    chk("reset_empty", empty, 1'b1);
    #3 rst_n = 1'b1;

    // Capture on start+push into an empty FIFO, then pop.
    step(1, 0, 1, 8'hA5);
    chk("t1_magic", magic_data, 8'hA5);
    step(0, 1, 0, 8'h00);
    chk("t1_vld", check_vld, 1'b1);
    chk("t1_pass", check_pass, 1'b1);
    step(0, 0, 0, 8'h00);

    // Three words ahead of the tagged one.
    step(1, 0, 0, 8'h01); step(1, 0, 0, 8'h02); step(1, 0, 0, 8'h03);
    step(0, 0, 1, 8'h00);
    chk("t2_armed", armed, 1'b1);
    step(1, 0, 0, 8'h5A);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 8'h00);
      chk("t2_vld_timing", check_vld, i == 3);
    end
    chk("t2_pass", check_pass, 1'b1);
    step(0, 0, 0, 8'h00);

    // Capture coinciding with an accepted pop.
    step(1, 0, 0, 8'h10); step(1, 0, 0, 8'h11);
    step(0, 0, 1, 8'h00);
    step(1, 1, 0, 8'h77);
    step(0, 1, 0, 8'h00);
    chk("t3_vld_early", check_vld, 1'b0);
    step(0, 1, 0, 8'h00);
    chk("t3_vld", check_vld, 1'b1);
    chk("t3_pass", check_pass, 1'b1);

    // Overflow while armed, then underflow.
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 8'(8'h20 + i));
    chk("t4_full", full, 1'b1);
    step(0, 0, 1, 8'h00);
    step(1, 0, 0, 8'hFF);
    chk("t4_no_capture", armed, 1'b1);
    chk("t4_full_hold", full, 1'b1);
    step(0, 0, 0, 8'h00);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    chk("t4_empty", empty, 1'b1);
    step(1, 0, 0, 8'h3C);
    step(0, 1, 0, 8'h00);
    chk("t4_pass", check_pass, 1'b1);

    // Corrupted head forces a failing check; err stays sticky across a later pass.
    step(0, 0, 1, 8'h00);
    step(1, 0, 0, 8'hC3);
    corrupt = 1;
    force dut.head = 8'h3C;
    step(0, 1, 0, 8'h00);
    release dut.head;
    corrupt = 0;
    chk("t5_vld", check_vld, 1'b1);
    chk("t5_fail", check_pass, 1'b0);
    chk("t5_err", err, 1'b1);
    step(0, 0, 1, 8'h00);
    chk("t5_rearm", armed, 1'b1);
    step(1, 0, 0, 8'h96);
    step(0, 1, 0, 8'h00);
    chk("t5_pass2", check_pass, 1'b1);
    chk("t5_err_sticky", err, 1'b1);

    // Reset while tracking with two words still ahead.
    step(1, 0, 0, 8'h41); step(1, 0, 0, 8'h42); step(1, 0, 0, 8'h43);
    step(0, 0, 1, 8'h00);
    step(1, 0, 0, 8'h44);
    step(0, 1, 0, 8'h00);
    chk("t6_tracking", tracking, 1'b1);
    async_reset();
    chk("t6_err_clr", err, 1'b0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 8'h00);

    // Pointer wrap: 20 push/pop pairs.
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0, 8'(i * 7 + 1));
      step(0, 1, 0, 8'h00);
    end
    step(1, 0, 0, 8'hE0);
    for (int i = 0; i < 20; i++) step(1, 1, 0, 8'(i + 8'h60));
    step(0, 1, 0, 8'h00);

    // Random traffic with occasional arming.
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
           $urandom_range(0, 7) == 0, 8'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
